// File: rtl/lsu_wb_pkg.sv
// Shared types and helpers for the lsu_wb writeback/load-store stage:
// writeback select, FSM states, funct3 width codes and store lane helpers.
package lsu_wb_pkg;

   typedef enum logic [1:0] {
      WB_PC4  = 2'b00,
      WB_ALU  = 2'b01,
      WB_LOAD = 2'b10
   } wb_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WB   = 2'b10,
      ERR  = 2'b11
   } lsu_state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Byte enables for an access of the given width at lane offset lo.
   function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] lo);
      logic [3:0] be;
      unique case ({1'b0, funct3[1:0]})
         SB:      be = 4'b0001 << lo;
         SH:      be = 4'b0011 << {lo[1], 1'b0};
         SW:      be = 4'b1111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
      logic [31:0] data;
      unique case ({1'b0, funct3[1:0]})
         SB:      data = {4{wdata[7:0]}};
         SH:      data = {2{wdata[15:0]}};
         SW:      data = wdata;
         default: data = wdata;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// Data-memory req/ack bus between lsu_wb (master) and the data memory (slave).
interface lsu_wb_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata;
   logic            ack;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/lsu_wb_load_align.sv
// load_align: picks the addressed byte/halfword out of a load word and
// sign- or zero-extends it according to funct3.
module load_align
   import lsu_wb_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sext;

   always_comb begin
      unique case (i_lo)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
      endcase
   end

   assign w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   assign w_sext = ~i_funct3[2];

   always_comb begin
      o_data = i_rdata;
      unique case (i_funct3)
         LB, LBU: o_data = {{24{w_sext & w_byte[7]}}, w_byte};
         LH, LHU: o_data = {{16{w_sext & w_half[15]}}, w_half};
         LW:      o_data = i_rdata;
         default: o_data = i_rdata;
      endcase
   end
endmodule

// File: rtl/lsu_wb.sv
// lsu_wb: final stage of the 3-stage RV32I pipeline -- data-memory access and writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of aligning them.
module lsu_wb
   import lsu_wb_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_reg_wr,
   input  logic            i_wr_en,
   input  logic            i_rd_en,
   input  logic [1:0]      i_wb_sel,
   input  logic [2:0]      i_funct3,
   input  logic [4:0]      i_rd,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_alu_res,
   input  logic [XLEN-1:0] i_pc4,
   input  logic [XLEN-1:0] i_wdata,
   output logic            o_stall,
   lsu_wb_if.master        mem,
   output logic            o_rf_we,
   output logic [4:0]      o_rf_waddr,
   output logic [XLEN-1:0] o_rf_wdata,
   output logic            o_bus_err,
   output logic            o_misaligned
);
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   lsu_state_e      r_state, w_state_nxt;
   logic [XLEN-1:0] r_addr, r_wdata, r_ldata;
   logic [3:0]      r_be;
   logic [2:0]      r_funct3;
   logic [4:0]      r_rd;
   logic [1:0]      r_lo;
   logic            r_reg_wr, r_we, r_mis;
   logic [7:0]      r_wait;

   logic [1:0]      w_lo;
   logic            w_mis, w_mem_op, w_latch, w_capture;
   logic [XLEN-1:0] w_load;

   assign w_mem_op = i_rd_en | i_wr_en;

   // Lane offset actually used: misaligned low bits are dropped for halfword/word.
   always_comb begin
      w_lo = i_addr[1:0];
      unique case ({1'b0, i_funct3[1:0]})
         SB:      w_lo = i_addr[1:0];
         SH:      w_lo = {i_addr[1], 1'b0};
         default: w_lo = 2'b00;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_mis        = (i_funct3[1:0] == 2'b01) ? i_addr[0]
                       : (i_funct3[1] ? (|i_addr[1:0]) : 1'b0);
   assign o_misaligned = (r_state == ERR) && r_mis;
`else
   assign w_mis        = 1'b0;
   assign o_misaligned = 1'b0;
`endif

   load_align u_load_align (
      .i_rdata  (mem.rdata),
      .i_lo     (r_lo),
      .i_funct3 (r_funct3),
      .o_data   (w_load)
   );

   assign mem.req   = (r_state == REQ);
   assign mem.we    = r_we;
   assign mem.addr  = r_addr;
   assign mem.be    = r_be;
   assign mem.wdata = r_wdata;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_capture   = 1'b0;
      o_stall     = 1'b0;
      o_rf_we     = 1'b0;
      o_rf_waddr  = i_rd;
      o_rf_wdata  = '0;
      o_bus_err   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_mem_op) begin
               o_stall     = 1'b1;
               w_latch     = 1'b1;
               w_state_nxt = w_mis ? ERR : REQ;
            end else begin
               o_rf_we = i_reg_wr && (i_rd != 5'd0);
               case (i_wb_sel)
                  WB_PC4:  o_rf_wdata = i_pc4;
                  WB_ALU:  o_rf_wdata = i_alu_res;
                  WB_LOAD: o_rf_wdata = '0;
                  default: o_rf_wdata = '0;
               endcase
            end
         end
         REQ: begin
            o_stall = 1'b1;
            if (mem.ack) begin
               if (r_we) begin
                  o_stall     = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = WB;
               end
            end else if (r_wait == WAIT_LAST) begin
               w_state_nxt = ERR;
            end
         end
         WB: begin
            o_rf_we     = r_reg_wr && (r_rd != 5'd0);
            o_rf_waddr  = r_rd;
            o_rf_wdata  = r_ldata;
            w_state_nxt = IDLE;
         end
         ERR: begin
            o_bus_err   = ~r_mis;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ldata  <= '0;
         r_be     <= '0;
         r_funct3 <= '0;
         r_rd     <= '0;
         r_lo     <= '0;
         r_reg_wr <= 1'b0;
         r_we     <= 1'b0;
         r_mis    <= 1'b0;
         r_wait   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_addr   <= {i_addr[XLEN-1:2], 2'b00};
            r_be     <= store_be(i_funct3, w_lo);
            r_wdata  <= store_data(i_funct3, i_wdata);
            r_funct3 <= i_funct3;
            r_rd     <= i_rd;
            r_lo     <= w_lo;
            r_reg_wr <= i_reg_wr;
            r_we     <= i_wr_en;
            r_mis    <= w_mis;
         end
         r_wait <= (r_state == REQ) ? r_wait + 8'd1 : 8'd0;
         if (w_capture) r_ldata <= w_load;
      end
   end
endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: a responder models the data memory and a
// scoreboard queue holds the register-file writes each scenario expects.
module tb_lsu_wb;
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } rf_exp_t;

   logic        clk, rstn;
   logic        reg_wr, wr_en, rd_en;
   logic [1:0]  wb_sel;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] addr, alu, pc4, wdata;
   logic        o_stall, o_rf_we, o_bus_err, o_misaligned;
   logic [4:0]  o_rf_waddr;
   logic [31:0] o_rf_wdata;

   int          checks = 0;
   int          failures = 0;
   rf_exp_t     sb_q[$];

   int          ack_after = 0;
   logic [31:0] mem_word = '0;
   int          req_total = 0;
   logic [31:0] ack_addr, ack_wdata;
   logic [3:0]  ack_be;
   logic        ack_we;

   lsu_wb_if #(.XLEN(32)) mem ();

   lsu_wb #(.XLEN(32), .MAX_WAIT(15)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_reg_wr     (reg_wr),
      .i_wr_en      (wr_en),
      .i_rd_en      (rd_en),
      .i_wb_sel     (wb_sel),
      .i_funct3     (funct3),
      .i_rd         (rd),
      .i_addr       (addr),
      .i_alu_res    (alu),
      .i_pc4        (pc4),
      .i_wdata      (wdata),
      .o_stall      (o_stall),
      .mem          (mem),
      .o_rf_we      (o_rf_we),
      .o_rf_waddr   (o_rf_waddr),
      .o_rf_wdata   (o_rf_wdata),
      .o_bus_err    (o_bus_err),
      .o_misaligned (o_misaligned)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: acks the ack_after-th REQ cycle of each request (0 = never).
   initial begin
      int req_cnt;
      req_cnt   = 0;
      mem.ack   = 1'b0;
      mem.rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         mem.ack = 1'b0;
         if (rstn && mem.req) begin
            req_total++;
            req_cnt++;
            if (ack_after != 0 && req_cnt == ack_after) begin
               mem.ack   = 1'b1;
               mem.rdata = mem_word;
               ack_addr  = mem.addr;
               ack_be    = mem.be;
               ack_we    = mem.we;
               ack_wdata = mem.wdata;
               req_cnt   = 0;
            end
         end else begin
            req_cnt = 0;
         end
      end
   end

   // Register-file write monitor: every write must match the oldest expected one.
   always @(negedge clk) begin
      if (rstn && o_rf_we) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL rf_write_unexpected got waddr=%0d wdata=%h expected no write", o_rf_waddr, o_rf_wdata);
         end else begin
            rf_exp_t e;
            e = sb_q.pop_front();
            if (o_rf_waddr !== e.rd || o_rf_wdata !== e.data) begin
               failures++;
               $display("FAIL rf_write got waddr=%0d wdata=%h expected waddr=%0d wdata=%h",
                        o_rf_waddr, o_rf_wdata, e.rd, e.data);
            end
         end
      end
   end

   function automatic void expect_rf(input logic [4:0] r, input logic [31:0] d);
      rf_exp_t e;
      e.rd   = r;
      e.data = d;
      sb_q.push_back(e);
   endfunction

   task automatic set_inputs(input logic rw, input logic we, input logic re, input logic [1:0] ws,
                             input logic [2:0] f3, input logic [4:0] r, input logic [31:0] a,
                             input logic [31:0] al, input logic [31:0] p4, input logic [31:0] wd);
      reg_wr = rw; wr_en = we; rd_en = re; wb_sel = ws; funct3 = f3;
      rd = r; addr = a; alu = al; pc4 = p4; wdata = wd;
   endtask

   task automatic drive_op(input logic rw, input logic we, input logic re, input logic [1:0] ws,
                           input logic [2:0] f3, input logic [4:0] r, input logic [31:0] a,
                           input logic [31:0] al, input logic [31:0] p4, input logic [31:0] wd);
      @(posedge clk);
      #1;
      set_inputs(rw, we, re, ws, f3, r, a, al, p4, wd);
   endtask

   task automatic idle();
      drive_op(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   // Counts cycles with o_stall high from the current cycle on; -1 if it never drops.
   task automatic count_stall(output int n);
      n = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!o_stall) return;
         n++;
      end
      n = -1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      set_inputs(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
      checks++; if (mem.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem.req); end
      checks++; if (o_rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", o_rf_we); end
      checks++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", o_bus_err); end
      checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", o_misaligned); end
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic test_alu();
      expect_rf(5'd5, 32'h0000_1234);
      drive_op(1, 0, 0, 2'b01, 3'b000, 5'd5, 32'h0, 32'h1234, 32'h0, 32'h0);
      @(negedge clk);
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", o_stall); end
      expect_rf(5'd3, 32'h0000_0104);
      drive_op(1, 0, 0, 2'b00, 3'b000, 5'd3, 32'h0, 32'h55, 32'h104, 32'h0);
      expect_rf(5'd4, 32'h0);
      drive_op(1, 0, 0, 2'b10, 3'b000, 5'd4, 32'h0, 32'h55, 32'h104, 32'h0);
      expect_rf(5'd6, 32'h0);
      drive_op(1, 0, 0, 2'b11, 3'b000, 5'd6, 32'h0, 32'h55, 32'h104, 32'h0);
      drive_op(1, 0, 0, 2'b01, 3'b000, 5'd0, 32'h0, 32'h77, 32'h0, 32'h0);
      drive_op(0, 0, 0, 2'b01, 3'b000, 5'd9, 32'h0, 32'h77, 32'h0, 32'h0);
      idle();
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL alu_pending got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_load();
      int n;
      mem_word  = 32'h80AA_55CC;
      ack_after = 2;
      expect_rf(5'd10, 32'hFFFF_FF80);
      drive_op(1, 0, 1, 2'b10, 3'b000, 5'd10, 32'h103, 32'h0, 32'h0, 32'h0);
      count_stall(n);
      checks++; if (n !== 3) begin failures++; $display("FAIL lb_stall got=%0d exp=3", n); end
      checks++; if (ack_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", ack_addr); end
      checks++; if (ack_we !== 1'b0) begin failures++; $display("FAIL lb_we got=%b exp=0", ack_we); end
      checks++; if (ack_be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", ack_be); end
      expect_rf(5'd11, 32'h0000_0080);
      drive_op(1, 0, 1, 2'b10, 3'b100, 5'd11, 32'h103, 32'h0, 32'h0, 32'h0);
      count_stall(n);
      checks++; if (n !== 3) begin failures++; $display("FAIL lbu_stall got=%0d exp=3", n); end
      idle();
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL load_pending got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_store();
      int n;
      ack_after = 1;
      drive_op(0, 1, 0, 2'b00, 3'b001, 5'd1, 32'h202, 32'h0, 32'h0, 32'hDEAD_BEEF);
      count_stall(n);
      checks++; if (n !== 1) begin failures++; $display("FAIL sh_stall got=%0d exp=1", n); end
      checks++; if (ack_addr !== 32'h200) begin failures++; $display("FAIL sh_addr got=%h exp=00000200", ack_addr); end
      checks++; if (ack_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", ack_be); end
      checks++; if (ack_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", ack_wdata); end
      checks++; if (ack_we !== 1'b1) begin failures++; $display("FAIL sh_we got=%b exp=1", ack_we); end
      // Both enables with reg_wr set: the store wins and nothing is written back.
      ack_after = 2;
      drive_op(1, 1, 1, 2'b10, 3'b000, 5'd2, 32'h101, 32'h0, 32'h0, 32'h1234_565A);
      count_stall(n);
      checks++; if (n !== 2) begin failures++; $display("FAIL sb_stall got=%0d exp=2", n); end
      checks++; if (ack_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", ack_we); end
      checks++; if (ack_be !== 4'b0010) begin failures++; $display("FAIL sb_be got=%b exp=0010", ack_be); end
      checks++; if (ack_wdata !== 32'h5A5A_5A5A) begin failures++; $display("FAIL sb_wdata got=%h exp=5a5a5a5a", ack_wdata); end
      idle();
   endtask

   task automatic test_timeout();
      int n;
      ack_after = 0;
      drive_op(1, 0, 1, 2'b10, 3'b010, 5'd12, 32'h400, 32'h0, 32'h0, 32'h0);
      count_stall(n);
      checks++; if (n !== 16) begin failures++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
      checks++; if (o_bus_err !== 1'b1) begin failures++; $display("FAIL timeout_bus_err got=%b exp=1", o_bus_err); end
      checks++; if (mem.req !== 1'b0) begin failures++; $display("FAIL timeout_req got=%b exp=0", mem.req); end
      idle();
      @(negedge clk);
      checks++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", o_bus_err); end
   endtask

   task automatic test_misalign();
      int n;
`ifdef LSU_MISALIGN_TRAP_EN
      int base;
      ack_after = 1;
      base      = req_total;
      drive_op(1, 0, 1, 2'b10, 3'b010, 5'd13, 32'h101, 32'h0, 32'h0, 32'h0);
      count_stall(n);
      checks++; if (n !== 1) begin failures++; $display("FAIL mis_stall got=%0d exp=1", n); end
      checks++; if (o_misaligned !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", o_misaligned); end
      checks++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL mis_bus_err got=%b exp=0", o_bus_err); end
      idle();
      @(negedge clk);
      checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL mis_pulse_end got=%b exp=0", o_misaligned); end
      checks++; if (req_total !== base) begin failures++; $display("FAIL mis_no_req got=%0d exp=%0d", req_total, base); end
`else
      mem_word  = 32'h1122_3344;
      ack_after = 1;
      expect_rf(5'd13, 32'h1122_3344);
      drive_op(1, 0, 1, 2'b10, 3'b010, 5'd13, 32'h101, 32'h0, 32'h0, 32'h0);
      count_stall(n);
      checks++; if (n !== 2) begin failures++; $display("FAIL lw_mis_stall got=%0d exp=2", n); end
      checks++; if (ack_addr !== 32'h100) begin failures++; $display("FAIL lw_mis_addr got=%h exp=00000100", ack_addr); end
      checks++; if (ack_be !== 4'b1111) begin failures++; $display("FAIL lw_mis_be got=%b exp=1111", ack_be); end
      mem_word = 32'h80AA_55CC;
      expect_rf(5'd14, 32'hFFFF_80AA);
      drive_op(1, 0, 1, 2'b10, 3'b001, 5'd14, 32'h103, 32'h0, 32'h0, 32'h0);
      count_stall(n);
      checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL lh_mis_flag got=%b exp=0", o_misaligned); end
      checks++; if (ack_be !== 4'b1100) begin failures++; $display("FAIL lh_mis_be got=%b exp=1100", ack_be); end
      idle();
`endif
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL mis_pending got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_reset_mid();
      ack_after = 0;
      drive_op(1, 0, 1, 2'b10, 3'b010, 5'd15, 32'h500, 32'h0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      checks++; if (mem.req !== 1'b1) begin failures++; $display("FAIL rstmid_req_before got=%b exp=1", mem.req); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (mem.req !== 1'b0) begin failures++; $display("FAIL rstmid_req_drop got=%b exp=0", mem.req); end
      set_inputs(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", o_stall); end
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (mem.req !== 1'b0) begin failures++; $display("FAIL rstmid_req_after got=%b exp=0", mem.req); end
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall_after got=%b exp=0", o_stall); end
   endtask

   task automatic test_back_to_back();
      int n;
      expect_rf(5'd7, 32'hAAAA_0001);
      drive_op(1, 0, 0, 2'b01, 3'b000, 5'd7, 32'h0, 32'hAAAA_0001, 32'h0, 32'h0);
      @(negedge clk);
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL b2b_alu_stall got=%b exp=0", o_stall); end
      mem_word  = 32'h8001_7FFF;
      ack_after = 1;
      expect_rf(5'd8, 32'hFFFF_8001);
      drive_op(1, 0, 1, 2'b10, 3'b001, 5'd8, 32'h106, 32'h0, 32'h0, 32'h0);
      count_stall(n);
      checks++; if (n !== 2) begin failures++; $display("FAIL b2b_lh_stall got=%0d exp=2", n); end
      checks++; if (ack_addr !== 32'h104) begin failures++; $display("FAIL b2b_lh_addr got=%h exp=00000104", ack_addr); end
      drive_op(0, 1, 0, 2'b00, 3'b010, 5'd0, 32'h300, 32'h0, 32'h0, 32'h0123_4567);
      count_stall(n);
      checks++; if (n !== 1) begin failures++; $display("FAIL b2b_sw_stall got=%0d exp=1", n); end
      checks++; if (ack_wdata !== 32'h0123_4567) begin failures++; $display("FAIL b2b_sw_wdata got=%h exp=01234567", ack_wdata); end
      expect_rf(5'd9, 32'h0000_0044);
      drive_op(1, 0, 0, 2'b00, 3'b000, 5'd9, 32'h0, 32'h0, 32'h44, 32'h0);
      @(negedge clk);
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL b2b_pc4_stall got=%b exp=0", o_stall); end
      idle();
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL b2b_pending got=%0d exp=0", sb_q.size()); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_misalign();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
